// File: rtl/ahb_burst_master.sv
// ahb_burst_master
//   Converts single-command burst requests into AHB-Lite master transfers.
//   One burst is in flight at a time. Address/control outputs are registered
//   from the latched command. BUSY insertion, the write-data pop strobe and
//   the read-data strobe are decoded combinationally so that each one lines up
//   with the cycle in which the bus actually completes a phase.
//
// Ports
//   hclk, hreset             clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (accepted when both are high)
//   cmd_addr/write/size/burst   burst start address, direction, hsize, hburst
//   wdata_valid/wdata_ready  write-data source; popped while wdata_ready is high
//   wdata                    write beat data
//   rdata_valid, rdata       read beat strobe and data (no backpressure)
//   haddr..hwdata            AHB-Lite master outputs
//   hready, hrdata           AHB-Lite slave response
module ahb_burst_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic [2:0]  cmd_burst,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [1:0]  htrans,
  output logic        hmastlock,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [31:0] hrdata
);

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  localparam logic [2:0] BURST_SINGLE = 3'd0;
  localparam logic [2:0] BURST_INCR   = 3'd1;
  localparam logic [2:0] BURST_WRAP4  = 3'd2;
  localparam logic [2:0] BURST_INCR4  = 3'd3;
  localparam logic [2:0] BURST_WRAP8  = 3'd4;
  localparam logic [2:0] BURST_INCR8  = 3'd5;
  localparam logic [2:0] BURST_WRAP16 = 3'd6;
  localparam logic [2:0] BURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    WAITW,
    ADDR,
    LAST
  } state_t;

  // Sizes wider than the 32-bit bus collapse to WORD.
  function automatic logic [2:0] clamp_size(input logic [2:0] sz);
    return (sz > SIZE_WORD) ? SIZE_WORD : sz;
  endfunction

  function automatic logic [4:0] burst_beats(input logic [2:0] b);
    logic [4:0] n;
    case (b)
      BURST_WRAP4, BURST_INCR4:   n = 5'd4;
      BURST_WRAP8, BURST_INCR8:   n = 5'd8;
      BURST_WRAP16, BURST_INCR16: n = 5'd16;
      default:                    n = 5'd1;  // SINGLE and undefined-length INCR
    endcase
    return n;
  endfunction

  // Next beat address. Wrapping bursts keep the upper bits fixed and let the
  // incremented low bits roll over inside the n*size-byte window.
  function automatic logic [31:0] next_addr(input logic [31:0] a,
                                            input logic [2:0]  sz,
                                            input logic [2:0]  b);
    logic [31:0] step;
    logic [31:0] inc;
    logic [31:0] span;
    step = 32'd1 << sz;
    inc  = a + step;
    case (b)
      BURST_WRAP4:  span = 32'd4 << sz;
      BURST_WRAP8:  span = 32'd8 << sz;
      BURST_WRAP16: span = 32'd16 << sz;
      default:      span = 32'd0;
    endcase
    if (span == 32'd0) begin
      return inc;
    end
    return (a & ~(span - 32'd1)) | (inc & (span - 32'd1));
  endfunction

  state_t      state;
  logic [1:0]  htrans_p0;    // registered NONSEQ/SEQ/IDLE for the address phase
  logic        seq_lock_p0;  // a SEQ beat stalled by hready must not turn BUSY
  logic [4:0]  beats_left;
  logic        vld_p1;       // a data phase is outstanding
  logic        wr_p1;        // direction of the outstanding data phase
  logic        addr_done;

  assign hprot     = HPROT_VAL;
  assign hmastlock = 1'b0;

  // Write beats after the first fall back to BUSY whenever the source has no
  // data, and rise to SEQ in the same cycle data appears. Once a SEQ has been
  // shown and stalled it is committed and stays SEQ.
  always_comb begin
    htrans = htrans_p0;
    if (state == ADDR && htrans_p0 == HTRANS_SEQ && hwrite &&
        !wdata_valid && !seq_lock_p0) begin
      htrans = HTRANS_BUSY;
    end
  end

  assign addr_done   = (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) && hready;
  assign cmd_ready   = (state == IDLE) && !hreset;
  assign wdata_ready = !hreset && addr_done && hwrite;
  assign rdata_valid = !hreset && vld_p1 && !wr_p1 && hready;
  assign rdata       = rdata_valid ? hrdata : 32'd0;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state       <= IDLE;
      htrans_p0   <= HTRANS_IDLE;
      seq_lock_p0 <= 1'b0;
      beats_left  <= 5'd0;
      haddr       <= 32'd0;
      hwrite      <= 1'b0;
      hsize       <= SIZE_BYTE;
      hburst      <= BURST_SINGLE;
      vld_p1      <= 1'b0;
      wr_p1       <= 1'b0;
      hwdata      <= 32'd0;
    end else begin
      // ---- address phase (p0) -> data phase (p1) ----
      if (addr_done) begin
        vld_p1 <= 1'b1;
        wr_p1  <= hwrite;
      end else if (hready) begin
        vld_p1 <= 1'b0;
      end
      if (wdata_ready) begin
        hwdata <= wdata;
      end

      // ---- command / address phase (p0) ----
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            haddr       <= cmd_addr;
            hwrite      <= cmd_write;
            hsize       <= clamp_size(cmd_size);
            hburst      <= cmd_burst;
            beats_left  <= burst_beats(cmd_burst);
            seq_lock_p0 <= 1'b0;
            if (cmd_write && !wdata_valid) begin
              state     <= WAITW;
              htrans_p0 <= HTRANS_IDLE;
            end else begin
              state     <= ADDR;
              htrans_p0 <= HTRANS_NONSEQ;
            end
          end
        end
        WAITW: begin
          if (wdata_valid) begin
            state     <= ADDR;
            htrans_p0 <= HTRANS_NONSEQ;
          end
        end
        ADDR: begin
          if (addr_done) begin
            haddr       <= next_addr(haddr, hsize, hburst);
            beats_left  <= beats_left - 5'd1;
            seq_lock_p0 <= 1'b0;
            if (beats_left == 5'd1) begin
              state     <= LAST;
              htrans_p0 <= HTRANS_IDLE;
            end else begin
              htrans_p0 <= HTRANS_SEQ;
            end
          end else if (htrans == HTRANS_SEQ) begin
            seq_lock_p0 <= 1'b1;
          end
        end
        LAST: begin
          // Wait for the final data phase so bursts never overlap.
          if (!vld_p1 || hready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_burst_master.sv
module tb_ahb_burst_master;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  logic        hclk;
  logic        hreset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [2:0]  cmd_size;
  logic [2:0]  cmd_burst;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_burst_master #(.HPROT_VAL(4'b0011)) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_write   (cmd_write),
    .cmd_size    (cmd_size),
    .cmd_burst   (cmd_burst),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .haddr       (haddr),
    .hwrite      (hwrite),
    .hsize       (hsize),
    .hburst      (hburst),
    .hprot       (hprot),
    .htrans      (htrans),
    .hmastlock   (hmastlock),
    .hwdata      (hwdata),
    .hready      (hready),
    .hrdata      (hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic sample();
    @(negedge hclk);
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [2:0] b);
    tick();
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_size  = sz;
    cmd_burst = b;
    sample();
    check_eq("accept_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic wait_cmd_ready(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      cmd_valid = 1'b0;
      sample();
      if (cmd_ready) seen = 1'b1;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  logic [31:0] wd [4];
  logic [31:0] s3_addr [4];
  int          s5_beat [13];
  int          pulses;

  initial begin
    wd      = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    s3_addr = '{32'h38, 32'h3C, 32'h30, 32'h34};
    s5_beat = '{0, 0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7, 0};

    hreset = 1'b1; cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_write = 1'b0;
    cmd_size = 3'd0; cmd_burst = 3'd0; wdata_valid = 1'b0; wdata = 32'd0;
    hready = 1'b1; hrdata = 32'd0;

    // ---------------- reset state ----------------
    tick(); tick();
    sample();
    check_eq("rst_htrans", 32'(htrans), 32'(T_IDLE));
    check_eq("rst_haddr", haddr, 32'd0);
    check_eq("rst_hwrite", 32'(hwrite), 32'd0);
    check_eq("rst_hsize", 32'(hsize), 32'd0);
    check_eq("rst_hburst", 32'(hburst), 32'd0);
    check_eq("rst_hwdata", hwdata, 32'd0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    check_eq("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("hprot", 32'(hprot), 32'h3);
    check_eq("hmastlock", 32'(hmastlock), 32'd0);
    tick();
    hreset = 1'b0;
    sample();
    check_eq("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---------------- S1: read SINGLE WORD at 0x100 ----------------
    issue(32'h100, 1'b0, 3'd2, 3'd0);
    tick(); cmd_valid = 1'b0;
    sample();
    check_eq("s1_c1_htrans", 32'(htrans), 32'(T_NONSEQ));
    check_eq("s1_c1_haddr", haddr, 32'h100);
    check_eq("s1_c1_hsize", 32'(hsize), 32'd2);
    check_eq("s1_c1_hburst", 32'(hburst), 32'd0);
    check_eq("s1_c1_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("s1_c1_rvalid", 32'(rdata_valid), 32'd0);
    tick(); hrdata = 32'hCAFE_0001;
    sample();
    check_eq("s1_c2_htrans", 32'(htrans), 32'(T_IDLE));
    check_eq("s1_c2_rvalid", 32'(rdata_valid), 32'd1);
    check_eq("s1_c2_rdata", rdata, 32'hCAFE_0001);
    tick();
    sample();
    check_eq("s1_c3_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("s1_c3_rvalid", 32'(rdata_valid), 32'd0);

    // ---------------- S2: write INCR4 WORD at 0x200, data always valid ----------------
    wdata_valid = 1'b1; wdata = wd[0];
    issue(32'h200, 1'b1, 3'd2, 3'd3);
    for (int i = 0; i < 4; i++) begin
      tick(); cmd_valid = 1'b0; wdata = wd[i];
      sample();
      check_eq("s2_htrans", 32'(htrans), (i == 0) ? 32'(T_NONSEQ) : 32'(T_SEQ));
      check_eq("s2_haddr", haddr, 32'h200 + 32'(4 * i));
      check_eq("s2_hwrite", 32'(hwrite), 32'd1);
      check_eq("s2_wready", 32'(wdata_ready), 32'd1);
      if (i > 0) check_eq("s2_hwdata", hwdata, wd[i-1]);
    end
    tick(); wdata_valid = 1'b0;
    sample();
    check_eq("s2_last_htrans", 32'(htrans), 32'(T_IDLE));
    check_eq("s2_last_hwdata", hwdata, wd[3]);
    check_eq("s2_last_wready", 32'(wdata_ready), 32'd0);
    tick();
    sample();
    check_eq("s2_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---------------- S3: read WRAP4 WORD at 0x38 ----------------
    issue(32'h38, 1'b0, 3'd2, 3'd2);
    pulses = 0;
    for (int c = 1; c <= 5; c++) begin
      tick(); cmd_valid = 1'b0; hrdata = 32'h0000_00A0 + 32'(c);
      sample();
      if (c <= 4) begin
        check_eq("s3_htrans", 32'(htrans), (c == 1) ? 32'(T_NONSEQ) : 32'(T_SEQ));
        check_eq("s3_haddr", haddr, s3_addr[c-1]);
      end else begin
        check_eq("s3_idle", 32'(htrans), 32'(T_IDLE));
      end
      check_eq("s3_rvalid", 32'(rdata_valid), (c >= 2) ? 32'd1 : 32'd0);
      if (rdata_valid) begin
        pulses++;
        check_eq("s3_rdata", rdata, 32'h0000_00A0 + 32'(c));
      end
    end
    check_eq("s3_pulses", 32'(pulses), 32'd4);
    tick();
    sample();
    check_eq("s3_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---------------- S4: write INCR4 with data gap before beat 3 ----------------
    wdata_valid = 1'b1; wdata = wd[0];
    issue(32'h200, 1'b1, 3'd2, 3'd3);
    tick(); cmd_valid = 1'b0;
    sample();
    check_eq("s4_c1_htrans", 32'(htrans), 32'(T_NONSEQ));
    check_eq("s4_c1_wready", 32'(wdata_ready), 32'd1);
    tick(); wdata = wd[1];
    sample();
    check_eq("s4_c2_haddr", haddr, 32'h204);
    check_eq("s4_c2_wready", 32'(wdata_ready), 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick(); wdata_valid = 1'b0;
      sample();
      check_eq("s4_busy_htrans", 32'(htrans), 32'(T_BUSY));
      check_eq("s4_busy_haddr", haddr, 32'h208);
      check_eq("s4_busy_wready", 32'(wdata_ready), 32'd0);
      check_eq("s4_busy_hwdata", hwdata, wd[1]);
    end
    tick(); wdata_valid = 1'b1; wdata = wd[2];
    sample();
    check_eq("s4_c5_htrans", 32'(htrans), 32'(T_SEQ));
    check_eq("s4_c5_haddr", haddr, 32'h208);
    check_eq("s4_c5_wready", 32'(wdata_ready), 32'd1);
    tick(); wdata = wd[3];
    sample();
    check_eq("s4_c6_haddr", haddr, 32'h20C);
    check_eq("s4_c6_hwdata", hwdata, wd[2]);
    tick(); wdata_valid = 1'b0;
    sample();
    check_eq("s4_c7_htrans", 32'(htrans), 32'(T_IDLE));
    check_eq("s4_c7_hwdata", hwdata, wd[3]);
    tick();
    sample();
    check_eq("s4_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---------------- S5: INCR8 HALFWORD read, hready low 3 cycles ----------------
    issue(32'h400, 1'b0, 3'd1, 3'd5);
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      tick(); cmd_valid = 1'b0;
      hready = !(c >= 3 && c <= 5);
      hrdata = 32'hB000_0000 + 32'(c);
      sample();
      if (c <= 11) begin
        check_eq("s5_htrans", 32'(htrans), (c == 1) ? 32'(T_NONSEQ) : 32'(T_SEQ));
        check_eq("s5_haddr", haddr, 32'h400 + 32'(2 * s5_beat[c]));
        check_eq("s5_hsize", 32'(hsize), 32'd1);
        check_eq("s5_hburst", 32'(hburst), 32'd5);
      end else begin
        check_eq("s5_idle", 32'(htrans), 32'(T_IDLE));
      end
      check_eq("s5_rvalid", 32'(rdata_valid), (c == 2 || c >= 6) ? 32'd1 : 32'd0);
      if (rdata_valid) begin
        pulses++;
        check_eq("s5_rdata", rdata, 32'hB000_0000 + 32'(c));
      end
    end
    check_eq("s5_pulses", 32'(pulses), 32'd8);
    tick(); hready = 1'b1;
    sample();
    check_eq("s5_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---------------- write with data not yet available (WAITW) ----------------
    wdata_valid = 1'b0;
    issue(32'h80, 1'b1, 3'd2, 3'd0);
    tick(); cmd_valid = 1'b0;
    sample();
    check_eq("ww_c1_htrans", 32'(htrans), 32'(T_IDLE));
    check_eq("ww_c1_cmd_ready", 32'(cmd_ready), 32'd0);
    tick(); wdata_valid = 1'b1; wdata = 32'h0000_1234;
    sample();
    check_eq("ww_c2_htrans", 32'(htrans), 32'(T_IDLE));
    check_eq("ww_c2_wready", 32'(wdata_ready), 32'd0);
    tick();
    sample();
    check_eq("ww_c3_htrans", 32'(htrans), 32'(T_NONSEQ));
    check_eq("ww_c3_haddr", haddr, 32'h80);
    check_eq("ww_c3_wready", 32'(wdata_ready), 32'd1);
    tick(); wdata_valid = 1'b0;
    sample();
    check_eq("ww_c4_hwdata", hwdata, 32'h0000_1234);
    check_eq("ww_c4_htrans", 32'(htrans), 32'(T_IDLE));
    tick();
    sample();
    check_eq("ww_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---------------- oversize cmd_size clamps to WORD ----------------
    issue(32'h40, 1'b0, 3'd3, 3'd3);
    tick(); cmd_valid = 1'b0;
    sample();
    check_eq("sz_hsize", 32'(hsize), 32'd2);
    check_eq("sz_haddr0", haddr, 32'h40);
    tick();
    sample();
    check_eq("sz_haddr1", haddr, 32'h44);
    wait_cmd_ready("sz_done", 10);

    // ---------------- S6: reset after beat 2 of an INCR8 read ----------------
    issue(32'h500, 1'b0, 3'd2, 3'd5);
    tick(); cmd_valid = 1'b0;
    sample();
    check_eq("s6_c1_haddr", haddr, 32'h500);
    tick();
    sample();
    check_eq("s6_c2_haddr", haddr, 32'h504);
    check_eq("s6_c2_rvalid", 32'(rdata_valid), 32'd1);
    tick(); hreset = 1'b1;
    sample();
    check_eq("s6_c3_rvalid", 32'(rdata_valid), 32'd0);
    check_eq("s6_c3_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    sample();
    check_eq("s6_rst_htrans", 32'(htrans), 32'(T_IDLE));
    check_eq("s6_rst_haddr", haddr, 32'd0);
    check_eq("s6_rst_hsize", 32'(hsize), 32'd0);
    check_eq("s6_rst_hburst", 32'(hburst), 32'd0);
    check_eq("s6_rst_hwdata", hwdata, 32'd0);
    check_eq("s6_rst_rvalid", 32'(rdata_valid), 32'd0);
    check_eq("s6_rst_rdata", rdata, 32'd0);
    tick(); hreset = 1'b0;
    sample();
    check_eq("s6_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("s6_rel_htrans", 32'(htrans), 32'(T_IDLE));
    for (int c = 0; c < 3; c++) begin
      tick();
      sample();
      check_eq("s6_no_rvalid", 32'(rdata_valid), 32'd0);
      check_eq("s6_no_wready", 32'(wdata_ready), 32'd0);
      check_eq("s6_idle", 32'(htrans), 32'(T_IDLE));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_burst_master.md
AHB_BURST_MASTER -- requirements
Module: ahb_burst_master

Interface
REQ-001 SHALL provide parameter HPROT_VAL, default 4'b0011, driven constant on hprot (non-cacheable, privileged data access).
REQ-002 SHALL provide ports, in this order:
- hclk  in  1  sole clock; all logic on rising edge.
- hreset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  32  start byte address.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_size  in  3  hsize_type.
- cmd_burst  in  3  hburst_type.
- wdata_valid  in  1  write data available.
- wdata_ready  out  1  write data popped this cycle.
- wdata  in  32  write beat data.
- rdata_valid  out  1  read beat returned, one-cycle pulse.
- rdata  out  32  read beat data.
- haddr  out  32  AHB address.
- hwrite  out  1  AHB transfer direction.
- hsize  out  3  AHB size, hsize_type.
- hburst  out  3  AHB burst, hburst_type.
- hprot  out  4  equals HPROT_VAL.
- htrans  out  2  AHB transfer type, htrans_type.
- hmastlock  out  1  tied 0.
- hwdata  out  32  AHB write data.
- hready  in  1  AHB ready.
- hrdata  in  32  AHB read data.

Function
REQ-003 SHALL implement states IDLE, WAITW, ADDR, LAST; cmd_ready SHALL be 1 only in IDLE with hreset low.
REQ-004 On command accept, SHALL latch addr/write/size/burst and load the beat count: SINGLE = 1, INCR = 1, WRAP4/INCR4 = 4, WRAP8/INCR8 = 8, WRAP16/INCR16 = 16.
REQ-005 cmd_size above WORD SHALL be treated as WORD for hsize and address increment.
REQ-006 After accept, state SHALL be ADDR, or WAITW when cmd_write = 1 and wdata_valid = 0; the first address phase SHALL appear the cycle after accept.
REQ-007 In WAITW, htrans SHALL be IDLE, and the block SHALL move to ADDR in the cycle wdata_valid = 1.
REQ-008 In ADDR, htrans SHALL be NONSEQ for the first beat and SEQ for later beats, with haddr, hwrite, hsize and hburst driven from the latched command.
REQ-009 Within a write burst, a non-first beat with wdata_valid = 0 SHALL be presented as BUSY; BUSY SHALL change to SEQ when wdata_valid rises.
REQ-010 A NONSEQ/SEQ address phase with hready = 0 SHALL hold all address/control outputs unchanged.
REQ-011 An address phase completes on NONSEQ/SEQ && hready = 1; the count SHALL then decrement and haddr SHALL advance.
REQ-012 INCR-type address advance: haddr + (1 << size).
REQ-013 WRAPn address advance: with B = n << size, next = (haddr & ~(B-1)) | ((haddr + (1 << size)) & (B-1)).
REQ-014 Write beats: wdata_ready SHALL be 1 exactly in the cycle a write address phase completes; hwdata SHALL load wdata at that edge and hold it until the following data phase completes with hready = 1.
REQ-015 Read beats: rdata_valid SHALL pulse 1 with rdata = hrdata in each cycle a read data phase completes with hready = 1; read data has no backpressure.
REQ-016 After the last address phase completes, state SHALL be LAST with htrans = IDLE.
REQ-017 LAST SHALL exit to IDLE when the final data phase completes, so cmd_ready = 1 the following cycle; bursts SHALL NOT overlap.
REQ-018 hready = 0 while htrans is IDLE or BUSY SHALL NOT stall state progression except as required by REQ-010.
REQ-019 INCR cross-1KB behaviour is out of scope; the command source guarantees legal bursts.

Reset
REQ-020 While hreset = 1 at a clock edge, the block SHALL set:
- state IDLE; htrans IDLE; haddr 0; hwrite 0; hsize BYTE; hburst SINGLE; hwdata 0;
- rdata_valid 0; rdata 0; wdata_ready 0; cmd_ready 0; beat count 0.
REQ-021 Reset mid-burst SHALL abandon the burst: no further wdata_ready or rdata_valid pulses, and cmd_ready = 1 the first cycle after hreset falls.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Read SINGLE WORD at 0x100, hready = 1 -> NONSEQ 0x100 in cycle 1, IDLE in cycle 2, rdata_valid with hrdata in cycle 2, cmd_ready in cycle 3.
- Write INCR4 WORD at 0x200, data A..D always valid -> NONSEQ 0x200, SEQ 0x204/0x208/0x20C; hwdata A..D one cycle behind each address.
- Read WRAP4 WORD at 0x38 -> haddr 0x38, 0x3C, 0x30, 0x34; four rdata_valid pulses.
- Write INCR4 with wdata_valid low before beat 3 for two cycles -> htrans BUSY twice holding haddr 0x208, then SEQ 0x208; no wdata_ready during BUSY.
- hready low 3 cycles during an INCR8 HALFWORD read -> address/control outputs held; haddr steps by 2; exactly 8 rdata_valid pulses.
- hreset asserted after beat 2 of an INCR8 read -> htrans IDLE and all outputs at reset values; cmd_ready = 1 the cycle after release.
